// File: rtl/grey_pkg.sv
// Shared types and constants for the grey counter reader: digit geometry,
// Johnson digit codes, FSM state encoding and the code-to-BCD decoder.
package grey_pkg;

    localparam int NDIGITS = 12;
    localparam int CODE_W  = 5;
    localparam int BCD_W   = 4;
    localparam int RAW_W   = NDIGITS * CODE_W;
    localparam int VAL_W   = NDIGITS * BCD_W;
    localparam int IO_W    = 8;
    localparam int SEL_W   = 6;

    localparam logic [CODE_W-1:0] JC_0 = 5'b00000;
    localparam logic [CODE_W-1:0] JC_1 = 5'b00001;
    localparam logic [CODE_W-1:0] JC_2 = 5'b00011;
    localparam logic [CODE_W-1:0] JC_3 = 5'b00111;
    localparam logic [CODE_W-1:0] JC_4 = 5'b01111;
    localparam logic [CODE_W-1:0] JC_5 = 5'b11111;
    localparam logic [CODE_W-1:0] JC_6 = 5'b11110;
    localparam logic [CODE_W-1:0] JC_7 = 5'b11100;
    localparam logic [CODE_W-1:0] JC_8 = 5'b11000;
    localparam logic [CODE_W-1:0] JC_9 = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SLOT,
        ST_CMP,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [BCD_W-1:0] nibble;
    } bcd_t;

    // Unrecognised patterns report nibble F with valid cleared.
    function automatic bcd_t johnson_to_bcd(input logic [CODE_W-1:0] code);
        bcd_t r;
        r.valid  = 1'b1;
        r.nibble = 4'hF;
        case (code)
            JC_0:    r.nibble = 4'd0;
            JC_1:    r.nibble = 4'd1;
            JC_2:    r.nibble = 4'd2;
            JC_3:    r.nibble = 4'd3;
            JC_4:    r.nibble = 4'd4;
            JC_5:    r.nibble = 4'd5;
            JC_6:    r.nibble = 4'd6;
            JC_7:    r.nibble = 4'd7;
            JC_8:    r.nibble = 4'd8;
            JC_9:    r.nibble = 4'd9;
            default: r.valid  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/grey_reader_if.sv
// Bundle between the reader, the grey counter it scans and the host that
// requests scans; master is the reader side, slave the counter/host side.
interface grey_reader_if;
    import grey_pkg::*;

    logic             start;
    logic [IO_W-1:0]  io_out;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             done;
    logic [VAL_W-1:0] value;
    logic             bad_code;
    logic             stale;

    modport master (
        input  start, io_out,
        output sel, busy, done, value, bad_code, stale
    );

    modport slave (
        output start, io_out,
        input  sel, busy, done, value, bad_code, stale
    );

endinterface

// File: rtl/grey_digit_decode.sv
// Combinational decode of one Johnson-coded digit to {valid, BCD nibble}.
module grey_digit_decode
    import grey_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic              valid_o,
    output logic [BCD_W-1:0]  bcd_o
);

    bcd_t dec;

    always_comb begin
        dec     = johnson_to_bcd(code_i);
        valid_o = dec.valid;
        bcd_o   = dec.nibble;
    end

endmodule

// File: rtl/grey_reader.sv
// Double-pass scanning reader for the 12-digit grey counter; a value is only
// published once two consecutive raw passes agree or the retries run out.
module grey_reader
    import grey_pkg::*;
#(
    parameter int unsigned SETTLE    = 1,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic          CLK,
    input  logic          RST,
    grey_reader_if.master bus
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);
    localparam logic [2:0] RETRY_C  = 3'(MAX_RETRY);
    localparam logic [3:0] LAST_IDX = 4'(NDIGITS - 1);

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             pass_q, pass_d;
    logic [2:0]       retry_q, retry_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [RAW_W-1:0] buf_a_q, buf_a_d;
    logic [RAW_W-1:0] buf_b_q, buf_b_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic             bad_q, bad_d;
    logic             stale_q, stale_d;

    logic [CODE_W-1:0]  code_in;
    logic [NDIGITS-1:0] dec_valid;
    logic [VAL_W-1:0]   dec_value;
    int unsigned        slot_lsb;
    logic               unused_io_hi;

    assign code_in      = bus.io_out[CODE_W-1:0];
    assign unused_io_hi = ^bus.io_out[IO_W-1:CODE_W];
    assign slot_lsb     = 32'(idx_q) * CODE_W;

    for (genvar g = 0; g < NDIGITS; g++) begin : g_dec
        grey_digit_decode u_dec (
            .code_i  (buf_b_q[g*CODE_W +: CODE_W]),
            .valid_o (dec_valid[g]),
            .bcd_o   (dec_value[g*BCD_W +: BCD_W])
        );
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    // NOTE: the pass buffers are plain flops and are reset with the rest, so
    // a fresh scan never compares against leftovers from an aborted one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pass_q  <= 1'b0;
            retry_q <= '0;
            cnt_q   <= '0;
            buf_a_q <= '0;
            buf_b_q <= '0;
            value_q <= '0;
            bad_q   <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
            value_q <= value_d;
            bad_q   <= bad_d;
            stale_q <= stale_d;
        end
    end

    // NOTE: every _d takes its hold value first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;
        value_d = value_q;
        bad_d   = bad_q;
        stale_d = stale_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SLOT;
                    idx_d   = '0;
                    pass_d  = 1'b0;
                    retry_d = '0;
                    cnt_d   = '0;
                end
            end

            ST_SLOT: begin
                if (cnt_q == SETTLE_C) begin
                    cnt_d = '0;
                    if (!pass_q) begin
                        buf_a_d[slot_lsb +: CODE_W] = code_in;
                    end else begin
                        buf_b_d[slot_lsb +: CODE_W] = code_in;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        pass_d = ~pass_q;
                        if (pass_q) begin
                            state_d = ST_CMP;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_CMP: begin
                if (buf_a_q != buf_b_q && retry_q < RETRY_C) begin
                    state_d = ST_SLOT;
                    retry_d = retry_q + 3'd1;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    // Raw-code agreement, or retries exhausted: publish B.
                    state_d = ST_DONE;
                    value_d = dec_value;
                    bad_d   = ~&dec_valid;
                    stale_d = (buf_a_q != buf_b_q);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.sel      = {2'b00, idx_q};
        bus.busy     = (state_q == ST_SLOT) || (state_q == ST_CMP);
        bus.done     = (state_q == ST_DONE);
        bus.value    = value_q;
        bus.bad_code = bad_q;
        bus.stale    = stale_q;
    end

endmodule
